sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO. Next generation of the team's FIFO block.
- Generalised data width and depth.
- Adds selectable first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full and almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- ADD_WIDTH, 5, address width; DEPTH = 2**ADD_WIDTH entries.
- DATA_WIDTH, 8, data word width.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, 28, almost_full asserted when count >= AF_THRESH (range 1..DEPTH).
- AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH (range 0..DEPTH-1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- a_Reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_WIDTH  write data.
- Wr_enable  in  1  write request.
- Read_enable  in  1  read request (FWFT=1: pop/acknowledge).
- flush  in  1  synchronous clear of contents and error flags.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADD_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async assert, sync release):
  - Pointers = 0; count = 0.
  - data_out = 0, data_valid = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
  - Memory contents are not cleared.
- Storage: DEPTH x DATA_WIDTH array.
  - Write and read pointers are ADD_WIDTH+1 bits with an extra wrap bit.
  - Address = low ADD_WIDTH bits; wraps from DEPTH-1 to 0.
  - full when the pointers differ only in the MSB.
  - empty when the pointers are equal.
- Accepted write = Wr_enable & (!full | rd_accept).
  - Stores data_in at wr_ptr; wr_ptr increments.
- Accepted read (rd_accept) = Read_enable & !empty.
  - rd_ptr increments.
- Simultaneous read and write:
  - Non-empty: both accepted; count unchanged.
  - Full: read frees the slot, write accepted; full stays 1.
  - Empty: read rejected (underflow set), write accepted; count becomes 1.
- Rejected write (Wr_enable & full & !rd_accept): data dropped; overflow <= 1 and stays set.
- Rejected read (Read_enable & empty): underflow <= 1 and stays set; data_out unchanged.
- count: +1 on write only, -1 on read only, unchanged otherwise.
- Flags are registered and derived from the next-state count, so they are valid in the same cycle as count.
- Standard mode (FWFT=0):
  - On an accepted read, data_out <= mem[rd_ptr] and data_valid <= 1, one cycle after Read_enable is sampled.
  - data_valid <= 0 on any cycle without an accepted read.
  - data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; data_valid = !empty.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
  - Read_enable pops: the next word appears after that edge.
- flush (synchronous, highest priority over Wr_enable/Read_enable):
  - Pointers = 0, count = 0, overflow = underflow = 0, data_valid = 0.
  - Flags take their reset values; data_out holds its value.
- Reset mid-operation: immediate return to reset state; in-flight write discarded.
- Parameter sanity: elaboration fails if AF_THRESH > DEPTH or AE_THRESH >= DEPTH.

Test Plan:
- Reset, then write 19 and 20, one read (FWFT=0) -> data_out=19, data_valid=1 one cycle after Read_enable; count 2->1; empty=0.
- Read from an empty FIFO after draining -> underflow=1 and stays 1; count=0; data_out holds 20.
- Write 34 random words with Read_enable=0 -> full=1 after word 32, count=32, overflow=1 after word 33; almost_full=1 from count 28.
- Drain all 32 words -> words match the first 32 written in order (wrap exercised); almost_empty=1 at count 4; empty=1 at 0.
- Full FIFO, Wr_enable=Read_enable=1 for 5 cycles -> count stays 32, no overflow, order preserved.
- FWFT=1: write 0xA5 into empty -> data_out=0xA5, data_valid=1 next cycle without Read_enable; flush mid-stream -> count=0, error flags cleared; a_Reset mid-write -> all outputs at reset values.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: producer/consumer signal bundle for sync_fifo_flags.
interface sync_fifo_flags_if #(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  Wr_enable;
    logic                  Read_enable;
    logic                  flush;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADD_WIDTH:0]    count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data_in, Wr_enable, Read_enable, flush,
        input  data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  data_in, Wr_enable, Read_enable, flush,
        output data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with optional FWFT read, occupancy count,
// programmable almost flags, sticky error flags and synchronous flush.
module sync_fifo_flags #(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input logic              clk,
    input logic              a_Reset,
    sync_fifo_flags_if.slave bus
);
    localparam int DEPTH = 2 ** ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] ONE     = (ADD_WIDTH + 1)'(1);
    localparam logic [ADD_WIDTH:0] FULL_C  = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [ADD_WIDTH:0] AF_C    = (ADD_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADD_WIDTH:0] AE_C    = (ADD_WIDTH + 1)'(AE_THRESH);

    generate
        if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_thresh
            $error("sync_fifo_flags: threshold parameters out of range");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADD_WIDTH:0]    r_wr_ptr, r_rd_ptr, r_count, w_count_nxt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dv, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic                  w_rd, w_wr;

    // flush dominates: neither side is accepted in a flush cycle
    assign w_rd = bus.Read_enable & ~r_empty & ~bus.flush;
    assign w_wr = bus.Wr_enable & (~r_full | w_rd) & ~bus.flush;

    always_comb begin
        w_count_nxt = bus.flush      ? '0 :
                      (w_wr & ~w_rd) ? r_count + ONE :
                      (w_rd & ~w_wr) ? r_count - ONE : r_count;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[ADD_WIDTH-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk or posedge a_Reset) begin
        if (a_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_dv     <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= bus.flush ? '0 : w_wr ? r_wr_ptr + ONE : r_wr_ptr;
            r_rd_ptr <= bus.flush ? '0 : w_rd ? r_rd_ptr + ONE : r_rd_ptr;
            r_count  <= w_count_nxt;
            r_full   <= w_count_nxt == FULL_C;
            r_empty  <= w_count_nxt == '0;
            r_af     <= w_count_nxt >= AF_C;
            r_ae     <= w_count_nxt <= AE_C;
            r_ovf    <= ~bus.flush & (r_ovf | (bus.Wr_enable & r_full & ~w_rd));
            r_unf    <= ~bus.flush & (r_unf | (bus.Read_enable & r_empty));
            r_dv     <= w_rd;
            if (w_rd) r_dout <= r_mem[r_rd_ptr[ADD_WIDTH-1:0]];
        end
    end

    assign bus.data_out     = (FWFT != 0) ? r_mem[r_rd_ptr[ADD_WIDTH-1:0]] : r_dout;
    assign bus.data_valid   = (FWFT != 0) ? ~r_empty : r_dv;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_af;
    assign bus.almost_empty = r_ae;
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;
endmodule
